// File: rtl/comparator_pool1_pkg.sv
// Shared FP16 field layout, result bit positions and helper for the pool1 comparator.
package comparator_pool1_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

  localparam int RES_LT_BIT    = 0;
  localparam int RES_UNORD_BIT = 1;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MAN_W-1:0]  man;
  } fp16_t;

  function automatic logic fp16_is_nan(input fp16_t x);
    return (x.exp == EXP_MAX) && (x.man != '0);
  endfunction
endpackage

// File: rtl/comparator_pool1_fp16_lt_core.sv
// Combinational binary16 ordering: raw sign/magnitude less-than plus NaN detection.
module fp16_lt_core
  import comparator_pool1_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        lt,
  output logic        unordered
);
  fp16_t       fa;
  fp16_t       fb;
  logic [14:0] mag_a;
  logic [14:0] mag_b;
  logic        both_zero;

  assign fa        = a;
  assign fb        = b;
  assign mag_a     = {fa.exp, fa.man};
  assign mag_b     = {fb.exp, fb.man};
  assign both_zero = (mag_a == '0) && (mag_b == '0);
  assign unordered = fp16_is_nan(fa) || fp16_is_nan(fb);

  // lt ignores NaN here; the caller masks it with unordered.
  always_comb begin
    lt = 1'b0;
    unique case ({fa.sign, fb.sign})
      2'b00:   lt = mag_a < mag_b;
      2'b01:   lt = 1'b0;
      2'b10:   lt = !both_zero;
      default: lt = mag_a > mag_b;
    endcase
  end
endmodule

// File: rtl/comparator_pool1.sv
// AXI4-Stream FP16 less-than comparator with LATENCY register stages and backpressure.
// Optional macro COMPARATOR_POOL1_UNORDERED_FLAG_EN drives tdata bit1 with the NaN flag.
module comparator_pool1
  import comparator_pool1_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] S_AXIS_A_tdata,
  input  logic        S_AXIS_A_tvalid,
  output logic        S_AXIS_A_tready,
  input  logic [15:0] S_AXIS_B_tdata,
  input  logic        S_AXIS_B_tvalid,
  output logic        S_AXIS_B_tready,
  output logic [7:0]  M_AXIS_RESULT_tdata,
  output logic        M_AXIS_RESULT_tvalid,
  input  logic        M_AXIS_RESULT_tready
);
  logic        en;
  logic        take;
  logic [15:0] a_p0;
  logic [15:0] b_p0;
  logic        vld_p0;
  logic        lt_raw_p0;
  logic        unord_p0;
  logic [1:0]  res_p0;
  logic [1:0]  res_out;
  logic        vld_out;

  assign en              = !(M_AXIS_RESULT_tvalid && !M_AXIS_RESULT_tready);
  assign take            = S_AXIS_A_tvalid && S_AXIS_B_tvalid;
  assign S_AXIS_A_tready = en;
  assign S_AXIS_B_tready = en;

  // Stage 0: capture the operand pair
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) vld_p0 <= 1'b0;
    else if (en)  vld_p0 <= take;
  end

  always_ff @(posedge aclk) begin
    if (en && take) begin
      a_p0 <= S_AXIS_A_tdata;
      b_p0 <= S_AXIS_B_tdata;
    end
  end

  fp16_lt_core u_core (
    .a         (a_p0),
    .b         (b_p0),
    .lt        (lt_raw_p0),
    .unordered (unord_p0)
  );

`ifdef COMPARATOR_POOL1_UNORDERED_FLAG_EN
  assign res_p0 = {unord_p0, lt_raw_p0 && !unord_p0};
`else
  assign res_p0 = {1'b0, lt_raw_p0 && !unord_p0};
`endif

  // Stages 1..LATENCY-1: carry the result bits and valid
  generate
    if (LATENCY == 1) begin : g_no_tail
      assign res_out = res_p0;
      assign vld_out = vld_p0;
    end else begin : g_tail
      logic [1:0]         res_pn [LATENCY-1];
      logic [LATENCY-2:0] vld_pn;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          vld_pn <= '0;
        end else if (en) begin
          vld_pn[0] <= vld_p0;
          for (int i = 1; i < LATENCY - 1; i++) vld_pn[i] <= vld_pn[i-1];
        end
      end

      always_ff @(posedge aclk) begin
        if (en) begin
          res_pn[0] <= res_p0;
          for (int i = 1; i < LATENCY - 1; i++) res_pn[i] <= res_pn[i-1];
        end
      end

      assign res_out = res_pn[LATENCY-2];
      assign vld_out = vld_pn[LATENCY-2];
    end
  endgenerate

  // Bubbles and reset present zero data.
  always_comb begin
    M_AXIS_RESULT_tdata = 8'h00;
    if (vld_out) begin
      M_AXIS_RESULT_tdata[RES_LT_BIT]    = res_out[0];
      M_AXIS_RESULT_tdata[RES_UNORD_BIT] = res_out[1];
    end
  end

  assign M_AXIS_RESULT_tvalid = vld_out;
endmodule

// File: tb/tb_comparator_pool1.sv
// Directed table-driven bench for comparator_pool1 plus stall, lone-valid and reset sequences.
module tb_comparator_pool1;
  import comparator_pool1_pkg::*;

  localparam int LAT = 5;
`ifdef COMPARATOR_POOL1_UNORDERED_FLAG_EN
  localparam logic [7:0] UN = 8'h02;
`else
  localparam logic [7:0] UN = 8'h00;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] a_data = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [15:0] b_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];

  comparator_pool1 #(.LATENCY(LAT)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .S_AXIS_A_tdata       (a_data),
    .S_AXIS_A_tvalid      (a_valid),
    .S_AXIS_A_tready      (a_ready),
    .S_AXIS_B_tdata       (b_data),
    .S_AXIS_B_tvalid      (b_valid),
    .S_AXIS_B_tready      (b_ready),
    .M_AXIS_RESULT_tdata  (r_data),
    .M_AXIS_RESULT_tvalid (r_valid),
    .M_AXIS_RESULT_tready (r_ready)
  );

  always #5 aclk = ~aclk;

  // Records every transfer that the next rising edge will complete.
  always @(negedge aclk) begin
    if (aresetn && r_valid && r_ready) got.push_back(r_data);
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_one(input vec_t v);
    int cyc;
    @(posedge aclk); #1;
    a_data = v.a; b_data = v.b; a_valid = 1'b1; b_valid = 1'b1;
    @(posedge aclk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    cyc = 1;
    while (!r_valid && cyc < 20) begin
      @(posedge aclk); #1;
      cyc++;
    end
    chk({v.name, "_latency"}, cyc, LAT);
    chk({v.name, "_data"}, {24'h0, r_data}, {24'h0, v.exp});
  endtask

  initial begin
    logic [7:0] held;
    int guard;

    vecs[0]  = '{16'h3C00, 16'h4000, 8'h01, "one_lt_two"};
    vecs[1]  = '{16'hC000, 16'hBC00, 8'h01, "neg2_lt_neg1"};
    vecs[2]  = '{16'hBC00, 16'hC000, 8'h00, "neg1_vs_neg2"};
    vecs[3]  = '{16'h8000, 16'h0000, 8'h00, "negzero_poszero"};
    vecs[4]  = '{16'h0000, 16'h8000, 8'h00, "poszero_negzero"};
    vecs[5]  = '{FP16_QNAN, 16'h3C00, UN, "nan_a"};
    vecs[6]  = '{16'h3C00, FP16_QNAN, UN, "nan_b"};
    vecs[7]  = '{FP16_NEG_INF, FP16_POS_INF, 8'h01, "ninf_lt_pinf"};
    vecs[8]  = '{FP16_POS_INF, FP16_POS_INF, 8'h00, "pinf_eq"};
    vecs[9]  = '{16'h0001, 16'h0002, 8'h01, "subnormals"};
    vecs[10] = '{16'h8001, 16'h0000, 8'h01, "negsub_lt_zero"};
    vecs[11] = '{16'h3C00, 16'h3C00, 8'h00, "equal"};
    vecs[12] = '{16'h7BFF, FP16_POS_INF, 8'h01, "max_lt_inf"};

    #2;
    chk("reset_tvalid", r_valid, 0);
    chk("reset_tdata", r_data, 0);
    chk("reset_tready", {a_ready, b_ready}, 2'b11);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;

    for (int i = 0; i < 13; i++) run_one(vecs[i]);

    // Eight back-to-back pairs with a three-cycle output stall.
    @(posedge aclk); #1;
    got.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a_data = vecs[i].a; b_data = vecs[i].b; a_valid = 1'b1; b_valid = 1'b1;
          @(negedge aclk);
          guard = 0;
          while (!a_ready && guard < 50) begin
            @(negedge aclk);
            guard++;
          end
          @(posedge aclk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge aclk);
        #1 r_ready = 1'b0;
        @(negedge aclk);
        held = r_data;
        chk("stall_tready", {a_ready, b_ready}, 2'b00);
        chk("stall_tvalid", r_valid, 1);
        for (int c = 0; c < 2; c++) begin
          @(negedge aclk);
          chk("stall_hold", {r_valid, r_data, a_ready}, {1'b1, held, 1'b0});
        end
        @(posedge aclk); #1 r_ready = 1'b1;
      end
    join
    repeat (15) @(posedge aclk);
    chk("stream_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("stream_order_%0d", i), got[i], vecs[i].exp);

    // A valid alone must not be consumed.
    @(posedge aclk); #1;
    got.delete();
    a_data = 16'hC000; b_data = 16'h3C00; a_valid = 1'b1;
    repeat (4) @(posedge aclk);
    repeat (LAT + 2) @(posedge aclk);
    chk("lone_a_no_output", got.size(), 0);
    #1 b_valid = 1'b1;
    @(posedge aclk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (12) @(posedge aclk);
    chk("lone_a_one_result", got.size(), 1);
    if (got.size() > 0) chk("lone_a_value", got[0], 8'h01);

    // Reset with three results in flight.
    @(posedge aclk); #1;
    r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_data = vecs[i].a; b_data = vecs[i].b; a_valid = 1'b1; b_valid = 1'b1;
      @(posedge aclk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    guard = 0;
    while (!r_valid && guard < 20) begin
      @(posedge aclk); #1;
      guard++;
    end
    chk("inflight_tvalid", r_valid, 1);
    @(negedge aclk); #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", r_valid, 0);
    chk("async_rst_tdata", r_data, 0);
    chk("async_rst_tready", {a_ready, b_ready}, 2'b11);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    r_ready = 1'b1;
    got.delete();
    repeat (12) @(posedge aclk);
    chk("no_stale_after_rst", got.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/comparator_pool1.md
Name: comparator_pool1

Overview:
- AXI4-Stream half-precision (IEEE 754 binary16) less-than comparator used by the pool1 max-pooling stage.
- Takes operands A and B on two slave streams and returns an 8-bit result on one master stream.
- Pooling logic forwards B when result == 1 (A < B), otherwise A.
- Pipelined with fixed latency and full backpressure support.

Parameters:
- LATENCY, 5, pipeline depth in cycles from the joint input handshake to M_AXIS_RESULT_tvalid (legal 1..8).

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- S_AXIS_A_tdata  input  16  operand A, binary16.
- S_AXIS_A_tvalid  input  1  operand A valid.
- S_AXIS_A_tready  output  1  operand A ready.
- S_AXIS_B_tdata  input  16  operand B, binary16.
- S_AXIS_B_tvalid  input  1  operand B valid.
- S_AXIS_B_tready  output  1  operand B ready.
- M_AXIS_RESULT_tdata  output  8  compare result; bit0 = (A < B), bits 7:1 zero.
- M_AXIS_RESULT_tvalid  output  1  result valid.
- M_AXIS_RESULT_tready  input  1  downstream ready.

Behaviour:
- Reset (aresetn low, asynchronous): every pipeline valid bit cleared; M_AXIS_RESULT_tvalid=0; M_AXIS_RESULT_tdata=8'h00; tready outputs follow the enable rule below (1 in reset).
- Pipeline enable: en = !(M_AXIS_RESULT_tvalid && !M_AXIS_RESULT_tready).
- S_AXIS_A_tready = S_AXIS_B_tready = en. Ready never depends on tvalid.
- Joint handshake: an operand pair is accepted on an edge where S_AXIS_A_tvalid && S_AXIS_B_tvalid && en.
- One valid alone is not consumed; its data is held by the source.
- Stage 0 captures A, B and a valid bit.
- LATENCY-1 further stages carry the computed bit and valid.
- All stages shift only when en=1. With continuous ready, the result appears exactly LATENCY cycles after acceptance, at one result per cycle.
- Stall: when tvalid=1 and tready=0, tdata and tvalid hold steady and no input is accepted.
- Compare rules:
  - A < B uses sign/magnitude ordering.
  - +0 and -0 are equal, so the result is 0.
  - Subnormals are ordered by value.
  - -Inf < finite < +Inf.
  - If either operand is NaN (exp=31, mantissa≠0), the result is 0 (unordered).
  - Equal values give 0.
- Bubbles (accepted cycles without valid) propagate as tvalid=0. tdata in bubble cycles is don't-care; implement as zero.
- Reset mid-operation discards all in-flight results immediately.

Optional Feature:
- Macro COMPARATOR_POOL1_UNORDERED_FLAG_EN.
- Defined: M_AXIS_RESULT_tdata bit1 = 1 when either operand is NaN. Bit0 is still 0 in that case.
- Undefined: bit1 is always 0.
- Bit0 timing and latency are identical in both builds.

Decomposition:
- Package comparator_pool1_pkg:
  - FP16 field widths: SIGN=1, EXP=5, MAN=10.
  - EXP_MAX=5'h1F.
  - RES_LT_BIT=0, RES_UNORD_BIT=1.
  - FP16 constants: +Inf 16'h7C00, -Inf 16'hFC00, QNaN 16'h7E00.
- One sub-module, fp16_lt_core: combinational, outputs lt and unordered from a and b; instantiated in stage 0.

Test Plan:
- A=16'h3C00 (1.0), B=16'h4000 (2.0), both valid, tready=1 -> tdata=8'h01, tvalid exactly 5 cycles after the handshake.
- A=16'hC000 (-2.0), B=16'hBC00 (-1.0) -> 8'h01. Swapped -> 8'h00. A=16'h8000, B=16'h0000 -> 8'h00.
- A=16'h7E00 (NaN), B=16'h3C00 -> 8'h00; 8'h02 with COMPARATOR_POOL1_UNORDERED_FLAG_EN. A=16'hFC00, B=16'h7C00 -> 8'h01.
- Stream 8 back-to-back pairs, then drop M_AXIS_RESULT_tready for 3 cycles -> s tready=0 while stalled, output held stable, no results lost or duplicated, order preserved.
- A valid without B valid for 4 cycles -> no acceptance, no output. B then valid -> exactly one result.
- Assert aresetn low with 3 results in flight -> tvalid drops without waiting for a clock edge; no stale result emitted after release.
